// File: rtl/async_fifo_wctrl_if.sv
// Write-side bundle of the dual-clock FIFO: producer request, RAM write port,
// pointer exchange with the read domain and the write-domain status flags.
interface async_fifo_wctrl_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  winc;
   logic [ADDR_WIDTH:0]   rptr_gray_async;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH:0]   wptr_gray;
   logic                  wfull;
   logic                  walmost_full;
   logic [ADDR_WIDTH:0]   wlevel;
   logic                  wovf;

   modport master (
      output winc,
      output rptr_gray_async,
      input  wen,
      input  waddr,
      input  wptr_gray,
      input  wfull,
      input  walmost_full,
      input  wlevel,
      input  wovf
   );

   modport slave (
      input  winc,
      input  rptr_gray_async,
      output wen,
      output waddr,
      output wptr_gray,
      output wfull,
      output walmost_full,
      output wlevel,
      output wovf
   );
endinterface

// File: rtl/async_fifo_wctrl.sv
// Write-side controller of the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchronizer and registered full/almost-full/level/overflow flags.
module async_fifo_wctrl #(
   parameter int ADDR_WIDTH  = 6,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_LEVEL = 60
) (
   input  logic              wclk,
   input  logic              rreset,
   async_fifo_wctrl_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] wgray_q;
   logic [PW-1:0] rq [SYNC_STAGES];
   logic [PW-1:0] rsync;
   logic [PW-1:0] rbin_sync;
   logic [PW-1:0] full_gray;
   logic [PW-1:0] level_next;
   logic [PW-1:0] wlevel_q;
   logic          wen_c;
   logic          wfull_q;
   logic          wafull_q;
   logic          wovf_q;

   assign wen_c      = bus.winc & ~wfull_q;
   assign wbin_next  = wbin + PW'(wen_c);
   assign wgray_next = wbin_next ^ (wbin_next >> 1);

   assign rsync = rq[SYNC_STAGES-1];

   always_comb begin
      rbin_sync = '0;
      rbin_sync[PW-1] = rsync[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         rbin_sync[i] = rbin_sync[i+1] ^ rsync[i];
      end
   end

   // Full when the next write pointer is exactly one lap ahead of the synchronized read pointer.
   assign full_gray  = {~rsync[PW-1:PW-2], rsync[PW-3:0]};
   assign level_next = wbin_next - rbin_sync;

   always_ff @(posedge wclk or posedge rreset) begin
      if (rreset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            rq[i] <= '0;
         end
         wbin     <= '0;
         wgray_q  <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wlevel_q <= '0;
         wovf_q   <= 1'b0;
      end else begin
         rq[0] <= bus.rptr_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rq[i] <= rq[i-1];
         end
         wbin     <= wbin_next;
         wgray_q  <= wgray_next;
         wfull_q  <= (wgray_next == full_gray);
         wafull_q <= (level_next >= AFULL_THR);
         wlevel_q <= level_next;
         wovf_q   <= wovf_q | (bus.winc & wfull_q);
      end
   end

   assign bus.wen          = wen_c;
   assign bus.waddr        = wbin[ADDR_WIDTH-1:0];
   assign bus.wptr_gray    = wgray_q;
   assign bus.wfull        = wfull_q;
   assign bus.walmost_full = wafull_q;
   assign bus.wlevel       = wlevel_q;
   assign bus.wovf         = wovf_q;
endmodule
